// File: rtl/avalon_bus_arbiter.sv
// rtl/avalon_bus_arbiter.sv - arbitrates fetch and data ports onto one Avalon master
// Optional ROUND_ROBIN_EN: ties alternate between ports instead of always favouring dm.
module avalon_bus_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [3:0]  dm_be,
    output logic [31:0] dm_rdata,
    output logic        dm_ack,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata,
    output logic        stall
);

    typedef enum logic [1:0] {IDLE, BUS_IF, BUS_DM, RESP} state_t;

    state_t      state;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;
    logic        lat_we;
    logic        grant_dm;

`ifdef ROUND_ROBIN_EN
    logic        last_dm;
    // On a tie dm wins only if fetch was the most recent grant.
    assign grant_dm = dm_req & (~if_req | ~last_dm);
`else
    assign grant_dm = dm_req;
`endif

    // Bus side is driven purely from the latched copy so it stays stable under waitrequest.
    assign address    = lat_addr & 32'hFFFF_FFFC;
    assign writedata  = lat_wdata;
    assign byteenable = lat_be;
    assign stall      = (if_req & ~if_ack) | (dm_req & ~dm_ack);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            lat_addr  <= 32'h0;
            lat_wdata <= 32'h0;
            lat_be    <= 4'h0;
            lat_we    <= 1'b0;
            read      <= 1'b0;
            write     <= 1'b0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            if_rdata  <= 32'h0;
            dm_rdata  <= 32'h0;
`ifdef ROUND_ROBIN_EN
            last_dm   <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_dm) begin
                        state     <= BUS_DM;
                        lat_addr  <= dm_addr;
                        lat_wdata <= dm_wdata;
                        lat_be    <= dm_be;
                        lat_we    <= dm_we;
                        read      <= ~dm_we;
                        write     <= dm_we;
`ifdef ROUND_ROBIN_EN
                        last_dm   <= 1'b1;
`endif
                    end else if (if_req) begin
                        state     <= BUS_IF;
                        lat_addr  <= if_addr;
                        lat_wdata <= 32'h0;
                        lat_be    <= 4'hF;
                        lat_we    <= 1'b0;
                        read      <= 1'b1;
                        write     <= 1'b0;
`ifdef ROUND_ROBIN_EN
                        last_dm   <= 1'b0;
`endif
                    end
                end
                BUS_IF: begin
                    if (!waitrequest) begin
                        if_rdata <= readdata;
                        read     <= 1'b0;
                        write    <= 1'b0;
                        if_ack   <= 1'b1;
                        state    <= RESP;
                    end
                end
                BUS_DM: begin
                    if (!waitrequest) begin
                        if (!lat_we) begin
                            dm_rdata <= readdata;
                        end
                        read   <= 1'b0;
                        write  <= 1'b0;
                        dm_ack <= 1'b1;
                        state  <= RESP;
                    end
                end
                RESP: begin
                    if_ack <= 1'b0;
                    dm_ack <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// tb/tb_avalon_bus_arbiter.sv - scoreboard bench for avalon_bus_arbiter
module tb_avalon_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        stall;

    always #5 clk = ~clk;

    avalon_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .address(address), .read(read), .write(write), .waitrequest(waitrequest),
        .writedata(writedata), .byteenable(byteenable), .readdata(readdata),
        .stall(stall)
    );

`ifdef ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } bus_t;

    typedef struct packed {
        logic        is_dm;
        logic [31:0] rdata;
        int          cyc;
    } ack_t;

    bus_t bus_q[$];
    ack_t ack_q[$];
    bus_t mon_b;
    ack_t mon_a;

    int cyc = 0;
    int compared = 0;
    int mismatched = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] slave_data(input logic [31:0] a);
        return (a == 32'hBFC0_0000) ? 32'h2402_000A : (a ^ 32'hC3C3_3C3C);
    endfunction

    assign readdata = slave_data(address);

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: bus strobes are checked against the head of bus_q every cycle they are up.
    always @(negedge clk) begin
        if (!reset) begin
            if (read || write) begin
                check32("strobe_excl", 32'(read & write), 32'h0);
                if (bus_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_bus: got addr %h rd %b wr %b expected none", address, read, write);
                end else begin
                    mon_b = bus_q[0];
                    check32("bus_addr", address, mon_b.addr);
                    check32("bus_read", 32'(read), 32'(mon_b.rd));
                    check32("bus_write", 32'(write), 32'(mon_b.wr));
                    check32("bus_wdata", writedata, mon_b.wdata);
                    check32("bus_be", 32'(byteenable), 32'(mon_b.be));
                    if (!waitrequest) mon_b = bus_q.pop_front();
                end
            end
            if (if_ack || dm_ack) begin
                if (ack_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_ack: got if_ack %b dm_ack %b expected none", if_ack, dm_ack);
                end else begin
                    mon_a = ack_q.pop_front();
                    check32("ack_dm", 32'(dm_ack), 32'(mon_a.is_dm));
                    check32("ack_if", 32'(if_ack), 32'(!mon_a.is_dm));
                    check32(mon_a.is_dm ? "dm_rdata" : "if_rdata",
                            mon_a.is_dm ? dm_rdata : if_rdata, mon_a.rdata);
                    check32("ack_cycle", 32'(cyc), 32'(mon_a.cyc));
                end
            end
        end
    end

    task automatic wait_done(input int n, input int waits);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (cyc == n + 1 + waits) waitrequest = 1'b0;
            if (if_ack) if_req = 1'b0;
            if (dm_ack) dm_req = 1'b0;
            if (!if_req && !dm_req) begin
                @(posedge clk); #1;
                return;
            end
        end
        compared++;
        mismatched++;
        $display("FAIL timeout: got if_req %b dm_req %b still pending expected both acked", if_req, dm_req);
        if_req = 1'b0;
        dm_req = 1'b0;
        waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic issue_if(input logic [31:0] a, input logic [31:0] exp_rd, input int waits);
        int n;
        n = cyc;
        bus_q.push_back('{addr: a & 32'hFFFF_FFFC, rd: 1'b1, wr: 1'b0, wdata: 32'h0, be: 4'hF});
        ack_q.push_back('{is_dm: 1'b0, rdata: exp_rd, cyc: n + 2 + waits});
        if_addr = a;
        if_req = 1'b1;
        waitrequest = (waits > 0);
        wait_done(n, waits);
    endtask

    task automatic issue_dm(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] be, input logic [31:0] exp_rd, input int waits);
        int n;
        n = cyc;
        bus_q.push_back('{addr: a & 32'hFFFF_FFFC, rd: !we, wr: we, wdata: wd, be: be});
        ack_q.push_back('{is_dm: 1'b1, rdata: exp_rd, cyc: n + 2 + waits});
        dm_we = we;
        dm_addr = a;
        dm_wdata = wd;
        dm_be = be;
        dm_req = 1'b1;
        waitrequest = (waits > 0);
        wait_done(n, waits);
    endtask

    task automatic do_tie(input logic [31:0] ia, input logic [31:0] ird,
                          input logic [31:0] da, input logic [31:0] drd, input bit if_first);
        int n;
        bus_t bi;
        bus_t bd;
        n = cyc;
        bi = '{addr: ia, rd: 1'b1, wr: 1'b0, wdata: 32'h0, be: 4'hF};
        bd = '{addr: da, rd: 1'b1, wr: 1'b0, wdata: 32'h0, be: 4'hF};
        if (if_first) begin
            bus_q.push_back(bi);
            bus_q.push_back(bd);
            ack_q.push_back('{is_dm: 1'b0, rdata: ird, cyc: n + 2});
            ack_q.push_back('{is_dm: 1'b1, rdata: drd, cyc: n + 5});
        end else begin
            bus_q.push_back(bd);
            bus_q.push_back(bi);
            ack_q.push_back('{is_dm: 1'b1, rdata: drd, cyc: n + 2});
            ack_q.push_back('{is_dm: 1'b0, rdata: ird, cyc: n + 5});
        end
        if_addr = ia;
        dm_addr = da;
        dm_we = 1'b0;
        dm_be = 4'hF;
        dm_wdata = 32'h0;
        waitrequest = 1'b0;
        if_req = 1'b1;
        dm_req = 1'b1;
        @(posedge clk); #1;
        check32("tie_stall", 32'(stall), 32'h1);
        wait_done(n, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish expected summary");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1;
        if_req = 1'b0;
        if_addr = 32'h0;
        dm_req = 1'b0;
        dm_we = 1'b0;
        dm_addr = 32'h0;
        dm_wdata = 32'h0;
        dm_be = 4'h0;
        waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check32("rst_read", 32'(read), 32'h0);
        check32("rst_write", 32'(write), 32'h0);
        check32("rst_if_ack", 32'(if_ack), 32'h0);
        check32("rst_dm_ack", 32'(dm_ack), 32'h0);
        check32("rst_if_rdata", if_rdata, 32'h0);
        check32("rst_dm_rdata", dm_rdata, 32'h0);
        check32("rst_address", address, 32'h0);
        check32("rst_stall", 32'(stall), 32'h0);
        @(posedge clk); #1;

        // Boot fetch with low address bits set.
        issue_if(32'hBFC0_0003, 32'h2402_000A, 0);
        // Load with all byte enables off; enables pass through untouched.
        issue_dm(1'b0, 32'h0000_2002, 32'hA5A5_A5A5, 4'b0000, 32'hC3C3_1C3C, 0);
        // Store stalled three cycles; dm_rdata keeps the previous load value.
        issue_dm(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'b0011, 32'hC3C3_1C3C, 3);

        // Fetch request dropped right after grant; dm raised while fetch is on the bus.
        n = cyc;
        bus_q.push_back('{addr: 32'h0000_0100, rd: 1'b1, wr: 1'b0, wdata: 32'h0, be: 4'hF});
        ack_q.push_back('{is_dm: 1'b0, rdata: 32'hC3C3_3D3C, cyc: n + 2});
        bus_q.push_back('{addr: 32'h0000_3008, rd: 1'b1, wr: 1'b0, wdata: 32'h0, be: 4'hF});
        ack_q.push_back('{is_dm: 1'b1, rdata: 32'hC3C3_0C34, cyc: n + 5});
        if_addr = 32'h0000_0100;
        if_req = 1'b1;
        waitrequest = 1'b0;
        @(posedge clk); #1;
        if_req = 1'b0;
        dm_we = 1'b0;
        dm_addr = 32'h0000_3008;
        dm_wdata = 32'h0;
        dm_be = 4'hF;
        dm_req = 1'b1;
        check32("drop_stall", 32'(stall), 32'h1);
        wait_done(n, 0);

        // Reset while a store is stalled on the bus.
        bus_q.push_back('{addr: 32'h0000_1004, rd: 1'b0, wr: 1'b1, wdata: 32'h55AA_55AA, be: 4'b1100});
        dm_we = 1'b1;
        dm_addr = 32'h0000_1004;
        dm_wdata = 32'h55AA_55AA;
        dm_be = 4'b1100;
        dm_req = 1'b1;
        waitrequest = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check32("pre_rst_write", 32'(write), 32'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        dm_req = 1'b0;
        waitrequest = 1'b0;
        bus_q.delete();
        check32("mid_rst_write", 32'(write), 32'h0);
        check32("mid_rst_read", 32'(read), 32'h0);
        check32("mid_rst_dm_rdata", dm_rdata, 32'h0);
        check32("mid_rst_if_rdata", if_rdata, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check32("mid_rst_no_ack", 32'(dm_ack), 32'h0);
        end

        // Ties straight after reset, then a lone fetch, then another tie.
        do_tie(32'h0000_0200, 32'hC3C3_3E3C, 32'h0000_4000, 32'hC3C3_7C3C, RR);
        issue_if(32'h0000_0204, 32'hC3C3_3E38, 0);
        do_tie(32'h0000_0200, 32'hC3C3_3E3C, 32'h0000_4000, 32'hC3C3_7C3C, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check32("bus_q_drained", 32'(bus_q.size()), 32'h0);
        check32("ack_q_drained", 32'(ack_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/avalon_bus_arbiter.md
AVALON_BUS_ARBITER -- requirements
Module: avalon_bus_arbiter

Interface
REQ-001 The block SHALL have the following ports; clk and reset first:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  instruction-fetch read request; held high until if_ack.
- if_addr  in  32  fetch byte address.
- if_rdata  out  32  fetched word; valid while if_ack=1.
- if_ack  out  1  one-cycle fetch completion pulse.
- dm_req  in  1  data request; held high until dm_ack.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  32  data byte address.
- dm_wdata  in  32  store data.
- dm_be  in  4  store/load byte enables.
- dm_rdata  out  32  loaded word; valid while dm_ack=1.
- dm_ack  out  1  one-cycle data completion pulse.
- address  out  32  Avalon master address.
- read  out  1  Avalon read strobe.
- write  out  1  Avalon write strobe.
- waitrequest  in  1  Avalon slave stall.
- writedata  out  32  Avalon write data.
- byteenable  out  4  Avalon byte enables.
- readdata  in  32  Avalon read data.
- stall  out  1  = (if_req & ~if_ack) | (dm_req & ~dm_ack); feeds the CPU state machine stall input.

Function
REQ-002 The FSM SHALL have states IDLE, BUS_IF, BUS_DM, RESP; encoding is free.
REQ-003 In IDLE with any request, the block SHALL select a winner (REQ-012), latch its addr/we/wdata/be into internal registers, and enter BUS_IF or BUS_DM next cycle.
REQ-004 In IDLE with no request, the block SHALL remain in IDLE; read=write=0.
REQ-005 In BUS_x, the block SHALL drive address = latched address with bits [1:0] forced to 0, and drive read/write, writedata and byteenable from the latched registers only.
REQ-006 Fetch transactions SHALL use read=1, write=0, byteenable=4'b1111, and writedata=0.
REQ-007 Data transactions SHALL use read=~we, write=we, byteenable=latched dm_be (including 4'b0000, which is issued unchanged), and writedata=latched dm_wdata.
REQ-008 A BUS_x cycle with waitrequest=0 SHALL complete the transaction: capture readdata into the winner's rdata register (reads only) and enter RESP; with waitrequest=1 it SHALL remain in BUS_x, with outputs stable, indefinitely.
REQ-009 In RESP, the winner's ack SHALL be 1 for exactly that cycle, read=write=0, all requests SHALL be ignored, and the next state SHALL be IDLE.
REQ-010 Minimum latency, with request at cycle N in IDLE and waitrequest=0: bus strobe at N+1, ack at N+2, IDLE at N+3.
REQ-011 A request deasserted mid-transaction SHALL NOT abort it; the transaction still completes and acks.
REQ-012 Simultaneous if_req and dm_req in IDLE SHALL be resolved per Configuration; the loser keeps waiting and stall stays high.
REQ-013 rdata outputs SHALL hold their last captured value between transactions; writes SHALL NOT update them.
REQ-014 At most one Avalon strobe SHALL be high in any cycle; read&write=1 is never driven.

Reset
REQ-015 While reset=1 at a clock edge, the next state SHALL be IDLE, regardless of state, including mid-transaction in BUS_x.
REQ-016 After reset: read=write=0, if_ack=dm_ack=0, if_rdata=dm_rdata=0, latched registers=0, last-grant=DM.
REQ-017 An in-flight transaction interrupted by reset SHALL produce no ack.

Configuration
REQ-018 With ROUND_ROBIN_EN defined, a tie SHALL be granted to the requester not granted last; the last-grant register updates on every grant.
REQ-019 Without ROUND_ROBIN_EN, a tie SHALL always be granted to dm; the last-grant register SHALL be absent or unused.

Verification
REQ-020 Fetch: if_req=1, if_addr=0xBFC00003, waitrequest=0, readdata=0x2402000A -> address=0xBFC00000, read=1 at N+1; if_ack=1 with if_rdata=0x2402000A at N+2.
REQ-021 Store with waitrequest held high 3 cycles: dm_we=1, dm_addr=0x1004, dm_wdata=0xDEADBEEF, dm_be=4'b0011 -> write=1 and outputs stable for 4 cycles; dm_ack at the 5th cycle; dm_rdata unchanged.
REQ-022 Tie after reset, ROUND_ROBIN_EN defined -> if first, then dm, then if; without the macro -> dm served while if_req is still pending and stall=1.
REQ-023 Reset asserted during BUS_DM with waitrequest=1 -> IDLE next cycle, write=0, dm_ack never pulses, dm_rdata=0.
REQ-024 if_req dropped one cycle after grant -> transaction completes; if_ack pulses once; no second grant in RESP, even with dm_req=1.
